// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter feeding the sdram_core request port through one registered
// slot; a tag FIFO of port ids routes the core's in-order read data back to its requester.
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int RD_TAG_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    p0_req_valid,
  output logic                    p0_req_ready,
  input  logic                    p0_req_we,
  input  logic [ADDR_WIDTH-1:0]   p0_req_addr,
  input  logic [DATA_WIDTH-1:0]   p0_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] p0_req_wmask,
  output logic                    p0_rsp_valid,
  output logic [DATA_WIDTH-1:0]   p0_rsp_rdata,
  input  logic                    p1_req_valid,
  output logic                    p1_req_ready,
  input  logic                    p1_req_we,
  input  logic [ADDR_WIDTH-1:0]   p1_req_addr,
  input  logic [DATA_WIDTH-1:0]   p1_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] p1_req_wmask,
  output logic                    p1_rsp_valid,
  output logic [DATA_WIDTH-1:0]   p1_rsp_rdata,
  output logic                    ctrl_req_valid,
  input  logic                    ctrl_req_ready,
  output logic                    ctrl_req_we,
  output logic [ADDR_WIDTH-1:0]   ctrl_req_addr,
  output logic [DATA_WIDTH-1:0]   ctrl_req_wdata,
  output logic [DATA_WIDTH/8-1:0] ctrl_req_wmask,
  input  logic                    ctrl_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   ctrl_rsp_rdata,
  output logic                    rsp_err
);
  localparam int          PW      = $clog2(RD_TAG_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(RD_TAG_DEPTH);

  typedef enum logic {EMPTY, FULL} slot_t;
  slot_t slot, slot_nxt;

  logic          last_grant;
  logic [PW:0]   rd_cnt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          tag_mem [RD_TAG_DEPTH];
  logic          head;
  logic          loadable, rd_room, elig0, elig1;
  logic          gnt_vld, gnt_port, acc_rd, pop;

  // Grant: decided in the same cycle the requester presents, only when the slot can take it.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_port = 1'b0;
    loadable = (slot == EMPTY) || ctrl_req_ready;
    rd_room  = rd_cnt < DEPTH_C;
    elig0    = p0_req_valid && (p0_req_we || rd_room);
    elig1    = p1_req_valid && (p1_req_we || rd_room);
    if (loadable) begin
      if (elig0 && elig1) begin
        gnt_vld  = 1'b1;
        gnt_port = ~last_grant;
      end else if (elig0) begin
        gnt_vld  = 1'b1;
        gnt_port = 1'b0;
      end else if (elig1) begin
        gnt_vld  = 1'b1;
        gnt_port = 1'b1;
      end
    end
    p0_req_ready = gnt_vld && !gnt_port;
    p1_req_ready = gnt_vld && gnt_port;
    acc_rd       = gnt_vld && !(gnt_port ? p1_req_we : p0_req_we);
    head         = tag_mem[rd_ptr];
    pop          = ctrl_rsp_valid && (rd_cnt != '0);
  end

  always_comb begin
    slot_nxt = slot;
    case (slot)
      EMPTY: if (gnt_vld) slot_nxt = FULL;
      FULL:  if (ctrl_req_ready && !gnt_vld) slot_nxt = EMPTY;
      default: slot_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot       <= EMPTY;
      last_grant <= 1'b1;
    end else begin
      slot <= slot_nxt;
      if (gnt_vld) last_grant <= gnt_port;
    end
  end

  assign ctrl_req_valid = (slot == FULL);

  // Request slot: registered copy of the granted request, held while the core stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_req_we    <= 1'b0;
      ctrl_req_addr  <= '0;
      ctrl_req_wdata <= '0;
      ctrl_req_wmask <= '0;
    end else if (gnt_vld) begin
      ctrl_req_we    <= gnt_port ? p1_req_we    : p0_req_we;
      ctrl_req_addr  <= gnt_port ? p1_req_addr  : p0_req_addr;
      ctrl_req_wdata <= gnt_port ? p1_req_wdata : p0_req_wdata;
      ctrl_req_wmask <= gnt_port ? p1_req_wmask : p0_req_wmask;
    end
  end

  // Tag FIFO control; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (acc_rd) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({acc_rd, pop})
        2'b10:   rd_cnt <= rd_cnt + 1'b1;
        2'b01:   rd_cnt <= rd_cnt - 1'b1;
        default: rd_cnt <= rd_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (acc_rd) tag_mem[wr_ptr] <= gnt_port;
  end

  // Response stage: route popped read data to the port recorded at the FIFO head.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_rsp_valid <= 1'b0;
      p1_rsp_valid <= 1'b0;
      p0_rsp_rdata <= '0;
      p1_rsp_rdata <= '0;
      rsp_err      <= 1'b0;
    end else begin
      p0_rsp_valid <= pop && !head;
      p1_rsp_valid <= pop && head;
      if (pop && !head) p0_rsp_rdata <= ctrl_rsp_rdata;
      if (pop && head)  p1_rsp_rdata <= ctrl_rsp_rdata;
      if (ctrl_rsp_valid && (rd_cnt == '0)) rsp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed scoreboard bench for sdram_port_arbiter: expected core requests and per-port
// read data are queued as stimulus is applied and checked when the DUT produces them.
module tb_sdram_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid;
  logic [31:0] p0_req_addr, p0_req_wdata, p0_rsp_rdata;
  logic [3:0]  p0_req_wmask;
  logic        p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid;
  logic [31:0] p1_req_addr, p1_req_wdata, p1_rsp_rdata;
  logic [3:0]  p1_req_wmask;
  logic        ctrl_req_valid, ctrl_req_ready, ctrl_req_we, ctrl_rsp_valid, rsp_err;
  logic [31:0] ctrl_req_addr, ctrl_req_wdata, ctrl_rsp_rdata;
  logic [3:0]  ctrl_req_wmask;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_TAG_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_wmask(p0_req_wmask),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_wmask(p1_req_wmask),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .ctrl_req_valid(ctrl_req_valid), .ctrl_req_ready(ctrl_req_ready), .ctrl_req_we(ctrl_req_we),
    .ctrl_req_addr(ctrl_req_addr), .ctrl_req_wdata(ctrl_req_wdata), .ctrl_req_wmask(ctrl_req_wmask),
    .ctrl_rsp_valid(ctrl_rsp_valid), .ctrl_rsp_rdata(ctrl_rsp_rdata), .rsp_err(rsp_err)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  req_t        exp_req[$];
  logic [31:0] exp_rsp0[$], exp_rsp1[$];
  int          tag_q[$];
  int          checks = 0;
  int          passes = 0;
  req_t        mon_e;
  logic [31:0] n0, n1, idx;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      p0_req_valid = v; p0_req_we = we; p0_req_addr = a; p0_req_wdata = d; p0_req_wmask = 4'hA;
    end else begin
      p1_req_valid = v; p1_req_we = we; p1_req_addr = a; p1_req_wdata = d; p1_req_wmask = 4'h5;
    end
  endtask

  task automatic push_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    req_t e;
    e.we = we; e.addr = a; e.wdata = d; e.wmask = (p == 0) ? 4'hA : 4'h5;
    exp_req.push_back(e);
    if (!we) tag_q.push_back(p);
  endtask

  task automatic ret(input logic [31:0] d);
    int p;
    ctrl_rsp_valid = 1'b1;
    ctrl_rsp_rdata = d;
    if (tag_q.size() > 0) begin
      p = tag_q.pop_front();
      if (p == 0) exp_rsp0.push_back(d);
      else        exp_rsp1.push_back(d);
    end
  endtask

  task automatic clear_model();
    exp_req.delete(); tag_q.delete(); exp_rsp0.delete(); exp_rsp1.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
  endtask

  // Scoreboard: compare every core handshake and every port response against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (ctrl_req_valid && ctrl_req_ready) begin
        chk1("ctrl_req_expected", exp_req.size() > 0, 1'b1);
        if (exp_req.size() > 0) begin
          mon_e = exp_req.pop_front();
          chk1("ctrl_we", ctrl_req_we, mon_e.we);
          chk32("ctrl_addr", ctrl_req_addr, mon_e.addr);
          chk32("ctrl_wdata", ctrl_req_wdata, mon_e.wdata);
          chk32("ctrl_wmask", {28'h0, ctrl_req_wmask}, {28'h0, mon_e.wmask});
        end
      end
      if (p0_rsp_valid) begin
        chk1("p0_rsp_expected", exp_rsp0.size() > 0, 1'b1);
        if (exp_rsp0.size() > 0) chk32("p0_rdata", p0_rsp_rdata, exp_rsp0.pop_front());
      end
      if (p1_rsp_valid) begin
        chk1("p1_rsp_expected", exp_rsp1.size() > 0, 1'b1);
        if (exp_rsp1.size() > 0) chk32("p1_rdata", p1_rsp_rdata, exp_rsp1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    ctrl_req_ready = 1'b1; ctrl_rsp_valid = 1'b0; ctrl_rsp_rdata = '0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(); tick();
    @(negedge clk);
    chk1("rst_ctrl_valid", ctrl_req_valid, 1'b0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk1("rst_p0_rsp_valid", p0_rsp_valid, 1'b0);
    chk1("rst_p1_rsp_valid", p1_rsp_valid, 1'b0);
    chk32("rst_ctrl_addr", ctrl_req_addr, 32'h0);
    chk32("rst_p0_rdata", p0_rsp_rdata, 32'h0);
    tick();
    rst = 1'b0;

    // Single port read, fixed latency to the core and back.
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    chk1("t1_p0_ready", p0_req_ready, 1'b1);
    chk1("t1_p1_ready", p1_req_ready, 1'b0);
    chk1("t1_ctrl_valid_T", ctrl_req_valid, 1'b0);
    push_req(0, 1'b0, 32'h100, 32'h0);
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk1("t1_ctrl_valid_T1", ctrl_req_valid, 1'b1);
    chk32("t1_ctrl_addr", ctrl_req_addr, 32'h100);
    tick();
    @(negedge clk);
    chk1("t1_ctrl_valid_T2", ctrl_req_valid, 1'b0);
    tick();
    ret(32'hDEADBEEF);
    @(negedge clk);
    chk1("t1_p0_rsp_early", p0_rsp_valid, 1'b0);
    tick();
    ctrl_rsp_valid = 1'b0;
    @(negedge clk);
    chk1("t1_p0_rsp_valid", p0_rsp_valid, 1'b1);
    chk1("t1_p1_rsp_valid", p1_rsp_valid, 1'b0);
    tick();

    // Contention from reset: strict alternation starting with port 0.
    do_reset();
    n0 = 32'h0; n1 = 32'h0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b1, 1'b1, 32'h1000 + n0, 32'hA000 + n0);
      drive(1, 1'b1, 1'b1, 32'h2000 + n1, 32'hB000 + n1);
      @(negedge clk);
      chk1($sformatf("t2_p0_ready_%0d", i), p0_req_ready, (i % 2) == 0);
      chk1($sformatf("t2_p1_ready_%0d", i), p1_req_ready, (i % 2) == 1);
      if ((i % 2) == 0) begin push_req(0, 1'b1, 32'h1000 + n0, 32'hA000 + n0); n0 = n0 + 1; end
      else              begin push_req(1, 1'b1, 32'h2000 + n1, 32'hB000 + n1); n1 = n1 + 1; end
      tick();
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(); tick();
    chk32("t2_grants_p0", n0, 32'd4);
    chk32("t2_grants_p1", n1, 32'd4);

    // Read limit: four outstanding reads block a fifth, writes still pass.
    for (int i = 0; i < 4; i++) begin
      idx = 32'(i);
      drive(0, 1'b1, 1'b0, 32'h3000 + idx, 32'h0);
      @(negedge clk);
      chk1($sformatf("t3_rd_ready_%0d", i), p0_req_ready, 1'b1);
      push_req(0, 1'b0, 32'h3000 + idx, 32'h0);
      tick();
    end
    drive(0, 1'b1, 1'b0, 32'h3100, 32'h0);
    drive(1, 1'b1, 1'b1, 32'h4000, 32'hC0DE);
    @(negedge clk);
    chk1("t3_rd5_blocked", p0_req_ready, 1'b0);
    chk1("t3_wr_accepted", p1_req_ready, 1'b1);
    push_req(1, 1'b1, 32'h4000, 32'hC0DE);
    tick();
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk1("t3_rd5_still_blocked", p0_req_ready, 1'b0);
    tick();
    ret(32'h5A5A0001);
    @(negedge clk);
    chk1("t3_pop_cycle_blocked", p0_req_ready, 1'b0);
    tick();
    ctrl_rsp_valid = 1'b0;
    @(negedge clk);
    chk1("t3_rd5_after_return", p0_req_ready, 1'b1);
    push_req(0, 1'b0, 32'h3100, 32'h0);
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      ret(32'h5A5A0010 + 32'(i));
      tick();
    end
    ctrl_rsp_valid = 1'b0;
    tick(); tick();

    // Backpressure: slot holds while the core stalls, then drains in grant order.
    ctrl_req_ready = 1'b0;
    drive(0, 1'b1, 1'b1, 32'h5000, 32'h11);
    @(negedge clk);
    chk1("t4_first_into_empty", p0_req_ready, 1'b1);
    push_req(0, 1'b1, 32'h5000, 32'h11);
    tick();
    drive(0, 1'b1, 1'b1, 32'h5001, 32'h22);
    drive(1, 1'b1, 1'b1, 32'h6000, 32'h33);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1($sformatf("t4_p0_ready_%0d", i), p0_req_ready, 1'b0);
      chk1($sformatf("t4_p1_ready_%0d", i), p1_req_ready, 1'b0);
      chk1($sformatf("t4_ctrl_valid_%0d", i), ctrl_req_valid, 1'b1);
      chk32($sformatf("t4_ctrl_addr_%0d", i), ctrl_req_addr, 32'h5000);
      chk32($sformatf("t4_ctrl_wdata_%0d", i), ctrl_req_wdata, 32'h11);
      tick();
    end
    ctrl_req_ready = 1'b1;
    @(negedge clk);
    chk1("t4_release_p1", p1_req_ready, 1'b1);
    chk1("t4_release_p0", p0_req_ready, 1'b0);
    push_req(1, 1'b1, 32'h6000, 32'h33);
    tick();
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk1("t4_then_p0", p0_req_ready, 1'b1);
    push_req(0, 1'b1, 32'h5001, 32'h22);
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(); tick(); tick();

    // Routing of interleaved reads.
    drive(0, 1'b1, 1'b0, 32'h7000, 32'h0);
    @(negedge clk);
    chk1("t5_rdA_ready", p0_req_ready, 1'b1);
    push_req(0, 1'b0, 32'h7000, 32'h0);
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h7100, 32'h0);
    @(negedge clk);
    chk1("t5_rdB_ready", p1_req_ready, 1'b1);
    push_req(1, 1'b0, 32'h7100, 32'h0);
    tick();
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(0, 1'b1, 1'b0, 32'h7200, 32'h0);
    @(negedge clk);
    chk1("t5_rdC_ready", p0_req_ready, 1'b1);
    push_req(0, 1'b0, 32'h7200, 32'h0);
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(); tick();
    ret(32'd1);
    tick();
    ret(32'd2);
    @(negedge clk);
    chk1("t5_rsp1_to_p0", p0_rsp_valid, 1'b1);
    tick();
    ret(32'd3);
    @(negedge clk);
    chk1("t5_rsp2_to_p1", p1_rsp_valid, 1'b1);
    chk1("t5_rsp2_not_p0", p0_rsp_valid, 1'b0);
    tick();
    ctrl_rsp_valid = 1'b0;
    @(negedge clk);
    chk1("t5_rsp3_to_p0", p0_rsp_valid, 1'b1);
    tick(); tick();
    chk32("t5_rsp0_drained", exp_rsp0.size(), 32'd0);
    chk32("t5_rsp1_drained", exp_rsp1.size(), 32'd0);
    chk32("t5_req_drained", exp_req.size(), 32'd0);

    // Response with nothing outstanding.
    ret(32'hBAD0);
    @(negedge clk);
    chk1("t6_err_not_yet", rsp_err, 1'b0);
    tick();
    ctrl_rsp_valid = 1'b0;
    @(negedge clk);
    chk1("t6_err_set", rsp_err, 1'b1);
    chk1("t6_no_p0_rsp", p0_rsp_valid, 1'b0);
    chk1("t6_no_p1_rsp", p1_rsp_valid, 1'b0);
    tick();

    // Reset in the middle of traffic.
    drive(0, 1'b1, 1'b0, 32'h8000, 32'h0);
    @(negedge clk);
    chk1("t7_rd0_ready", p0_req_ready, 1'b1);
    push_req(0, 1'b0, 32'h8000, 32'h0);
    tick();
    drive(0, 1'b1, 1'b0, 32'h8004, 32'h0);
    @(negedge clk);
    chk1("t7_rd1_ready", p0_req_ready, 1'b1);
    push_req(0, 1'b0, 32'h8004, 32'h0);
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    ctrl_req_ready = 1'b0;
    @(negedge clk);
    chk1("t7_slot_full", ctrl_req_valid, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    ctrl_req_ready = 1'b1;
    @(negedge clk);
    chk1("t7_ctrl_valid_cleared", ctrl_req_valid, 1'b0);
    chk32("t7_ctrl_addr_cleared", ctrl_req_addr, 32'h0);
    chk1("t7_err_cleared", rsp_err, 1'b0);
    chk1("t7_p0_rsp_cleared", p0_rsp_valid, 1'b0);
    tick();
    ret(32'hF00D);
    @(negedge clk);
    tick();
    ctrl_rsp_valid = 1'b0;
    @(negedge clk);
    chk1("t7_late_rsp_err", rsp_err, 1'b1);
    chk1("t7_late_no_p0_rsp", p0_rsp_valid, 1'b0);
    tick(); tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
